// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg
//  Shared types and default sizes for the register-bank request controller.
//  Contents:
//    NREG_DEFAULT / DW_DEFAULT / AW_DEFAULT : default bank geometry
//    state_t                                : controller FSM states
//    req_t                                  : one request at default geometry,
//                                             for issue logic built at defaults
// ----------------------------------------------------------------------------
package regfile_pkg;

    localparam int NREG_DEFAULT = 8;
    localparam int DW_DEFAULT   = 32;
    localparam int AW_DEFAULT   = $clog2(NREG_DEFAULT);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic                  wr;
        logic [AW_DEFAULT-1:0] waddr;
        logic [DW_DEFAULT-1:0] wdata;
        logic                  rd_a;
        logic [AW_DEFAULT-1:0] raddr_a;
        logic                  rd_b;
        logic [AW_DEFAULT-1:0] raddr_b;
    } req_t;

endpackage

// File: rtl/regfile_port_ctrl_onehot_decoder.sv
// ----------------------------------------------------------------------------
// onehot_decoder
//  Binary index to one-hot vector, gated by an enable. All zeros when en=0.
//  Ports:
//    en      in  1   gate; output is zero when low
//    addr    in  AW  index of the bit to set
//    onehot  out N   one-hot (en=1) or zero (en=0)
// ----------------------------------------------------------------------------
module onehot_decoder #(
    parameter int AW = 3,
    parameter int N  = 1 << AW
) (
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  onehot
);

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment; a path that leaves it unassigned infers a latch.
    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_port_ctrl.sv
// ----------------------------------------------------------------------------
// regfile_port_ctrl
//  Request-side controller for a bank of NREG two-read-port registers that
//  share tri-state read buses A and B. One write + dual-read request is taken
//  per valid/ready handshake, driven onto the bank for exactly one ACCESS
//  cycle, and the bus values are captured into a response held until consumed.
//
//  Optional feature: define REGFILE_BYPASS_EN to return the new write data on
//  a read port whose address matches the write address in the same request.
//  Without it such a read returns the pre-write contents seen on the bus.
//
//  Ports:
//    clk, rst                 clock; asynchronous active-high reset
//    req_valid / req_ready    request handshake (ready only in IDLE)
//    req_wr, req_waddr,       write enable, index, data
//    req_wdata
//    req_rdA, req_raddrA      port-A read enable, index
//    req_rdB, req_raddrB      port-B read enable, index
//    rsp_valid / rsp_ready    response handshake
//    rsp_dataA, rsp_dataB     captured read data (0 for an unrequested port)
//    bank_D                   shared write data bus (0 outside ACCESS)
//    bank_wr_en               one-hot write enables (ACCESS only)
//    bank_rdA, bank_rdB       one-hot read enables (ACCESS only)
//    bus_a, bus_b             shared read buses from the bank
// ----------------------------------------------------------------------------
module regfile_port_ctrl
    import regfile_pkg::*;
#(
    parameter  int NREG = NREG_DEFAULT,
    parameter  int DW   = DW_DEFAULT,
    localparam int AW   = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_wr,
    input  logic [AW-1:0]   req_waddr,
    input  logic [DW-1:0]   req_wdata,
    input  logic            req_rdA,
    input  logic [AW-1:0]   req_raddrA,
    input  logic            req_rdB,
    input  logic [AW-1:0]   req_raddrB,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_dataA,
    output logic [DW-1:0]   rsp_dataB,

    output logic [DW-1:0]   bank_D,
    output logic [NREG-1:0] bank_wr_en,
    output logic [NREG-1:0] bank_rdA,
    output logic [NREG-1:0] bank_rdB,
    input  logic [DW-1:0]   bus_a,
    input  logic [DW-1:0]   bus_b
);

    // Latched request at this instance's geometry (same layout as req_t).
    typedef struct packed {
        logic          wr;
        logic [AW-1:0] waddr;
        logic [DW-1:0] wdata;
        logic          rd_a;
        logic [AW-1:0] raddr_a;
        logic          rd_b;
        logic [AW-1:0] raddr_b;
    } lat_req_t;

    state_t   state;
    state_t   state_next;
    lat_req_t req_q;
    logic     accept;
    logic     in_access;
    logic [DW-1:0] cap_a;
    logic [DW-1:0] cap_b;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        in_access  = 1'b0;
        rsp_valid  = 1'b0;
        // Ready is gated by rst so nothing is advertised while held in reset.
        req_ready  = (state == IDLE) && !rst;

        case (state)
            IDLE: begin
                if (req_valid && req_ready) begin
                    accept     = 1'b1;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                in_access  = 1'b1;
                state_next = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Request latch: fields are held for the whole ACCESS cycle so the
    // issue side may change its inputs right after the handshake.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q <= '0;
        end else if (accept) begin
            req_q <= '{
                wr:      req_wr,
                waddr:   req_waddr,
                wdata:   req_wdata,
                rd_a:    req_rdA,
                raddr_a: req_raddrA,
                rd_b:    req_rdB,
                raddr_b: req_raddrB
            };
        end
    end

    // ------------------------------------------------------------------
    // Bank drive: enables exist only in ACCESS. They are decoded from the
    // state register, so an async reset clears them without waiting for
    // an edge and the write can never land.
    // ------------------------------------------------------------------
    onehot_decoder #(.AW(AW), .N(NREG)) u_dec_wr (
        .en     (in_access && req_q.wr),
        .addr   (req_q.waddr),
        .onehot (bank_wr_en)
    );

    onehot_decoder #(.AW(AW), .N(NREG)) u_dec_rd_a (
        .en     (in_access && req_q.rd_a),
        .addr   (req_q.raddr_a),
        .onehot (bank_rdA)
    );

    onehot_decoder #(.AW(AW), .N(NREG)) u_dec_rd_b (
        .en     (in_access && req_q.rd_b),
        .addr   (req_q.raddr_b),
        .onehot (bank_rdB)
    );

    assign bank_D = in_access ? req_q.wdata : '0;

    // ------------------------------------------------------------------
    // Capture values. The bus carries the register's pre-write contents
    // during ACCESS; the bypass build substitutes the new data on a
    // matching address while still asserting the read enable.
    // ------------------------------------------------------------------
    always_comb begin
        cap_a = '0;
        cap_b = '0;
        if (req_q.rd_a) begin
`ifdef REGFILE_BYPASS_EN
            cap_a = (req_q.wr && (req_q.raddr_a == req_q.waddr)) ? req_q.wdata : bus_a;
`else
            cap_a = bus_a;
`endif
        end
        if (req_q.rd_b) begin
`ifdef REGFILE_BYPASS_EN
            cap_b = (req_q.wr && (req_q.raddr_b == req_q.waddr)) ? req_q.wdata : bus_b;
`else
            cap_b = bus_b;
`endif
        end
    end

    // Response data is captured at the edge closing ACCESS and held
    // through RESP (and IDLE) until the next request's capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_dataA <= '0;
            rsp_dataB <= '0;
        end else if (in_access) begin
            rsp_dataA <= cap_a;
            rsp_dataB <= cap_b;
        end
    end

endmodule
